// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, default latencies and data word type for the multiply/divide unit.
package mdu_pkg;
    typedef logic [31:0] word_t;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 32x32 multiply / 32/32 divide producing {hi,lo}; wr=0 flags a zero divisor.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [1:0]  op,
    input  word_t       a,
    input  word_t       b,
    output logic [63:0] res,
    output logic        wr
);
    logic [63:0] ea, eb, prod;
    word_t       bs, sq, sr, uq, ur;
    logic        ovf;
    always_comb begin
        ea   = op[0] ? {32'b0, a} : {{32{a[31]}}, a};
        eb   = op[0] ? {32'b0, b} : {{32{b[31]}}, b};
        prod = ea * eb;
        // a safe divisor keeps the unused quotient defined when b is zero
        bs   = (b == 32'b0) ? 32'd1 : b;
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        sq   = ovf ? 32'h8000_0000 : word_t'($signed(a) / $signed(bs));
        sr   = ovf ? 32'b0 : word_t'($signed(a) % $signed(bs));
        uq   = a / bs;
        ur   = a % bs;
        res  = !op[1] ? prod : op[0] ? {ur, uq} : {sr, sq};
        wr   = !op[1] || (b != 32'b0);
    end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle HI/LO multiply/divide unit with mthi/mtlo writes.
// Optional MDU_START_BUSY_EN makes Busy also reflect Start combinationally.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    input  logic        HiLo,
    input  logic [1:0]  Op,
    input  logic        Start,
    input  logic        We,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    logic [CW-1:0] cnt;
    logic [63:0]   res, pend;
    logic          wr, pend_wr, busy_q;
    mdu_arith u_arith (.op(Op), .a(D1), .b(D2), .res(res), .wr(wr));
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            HI      <= '0;
            LO      <= '0;
            busy_q  <= 1'b0;
            cnt     <= '0;
            pend    <= '0;
            pend_wr <= 1'b0;
        end else if (busy_q) begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
                busy_q <= 1'b0;
                if (pend_wr) {HI, LO} <= pend;
            end
        end else if (Start) begin
            pend    <= res;
            pend_wr <= wr;
            cnt     <= Op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            busy_q  <= 1'b1;
        end else if (We) begin
            if (HiLo) HI <= D1;
            else      LO <= D1;
        end
    end
`ifdef MDU_START_BUSY_EN
    assign Busy = busy_q | Start;
`else
    assign Busy = busy_q;
`endif
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;
    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [31:0] D1 = '0, D2 = '0;
    logic        HiLo = 1'b0, Start = 1'b0, We = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic        Busy;
    logic [31:0] HI, LO;
    int          vecs = 0, errs = 0, n;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clk(Clk), .Rst(Rst), .D1(D1), .D2(D2), .HiLo(HiLo), .Op(Op),
        .Start(Start), .We(We), .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        Op = op; D1 = a; D2 = b; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0; D1 = 32'h5A5A_5A5A; D2 = 32'hA5A5_A5A5;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (Busy === 1'b1 && cycles < 100) begin
            cycles++;
            @(negedge Clk);
        end
    endtask

    task automatic write(input logic hl, input logic [31:0] d);
        We = 1'b1; HiLo = hl; D1 = d;
        @(negedge Clk);
        We = 1'b0;
    endtask

    initial begin
        Rst = 1'b0;
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        chk("reset_hi", HI, 32'h0);
        chk("reset_lo", LO, 32'h0);
        chk("reset_busy", {31'b0, Busy}, 32'h0);

        write(1'b1, 32'h1234_5678);
        chk("mthi_hi", HI, 32'h1234_5678);
        chk("mthi_lo", LO, 32'h0);
        chk("mthi_busy", {31'b0, Busy}, 32'h0);
        write(1'b0, 32'hCAFE_BABE);
        chk("mtlo_lo", LO, 32'hCAFE_BABE);
        chk("mtlo_hi", HI, 32'h1234_5678);

        launch(2'b00, 32'hFFFF_FFFE, 32'd3);
        chk("mult_hi_held", HI, 32'h1234_5678);
        wait_done(n);
        chk("mult_cycles", n, 32'd5);
        chk("mult_hi", HI, 32'hFFFF_FFFF);
        chk("mult_lo", LO, 32'hFFFF_FFFA);

        launch(2'b01, 32'hFFFF_FFFE, 32'd3);
        wait_done(n);
        chk("multu_cycles", n, 32'd5);
        chk("multu_hi", HI, 32'h0000_0002);
        chk("multu_lo", LO, 32'hFFFF_FFFA);

        launch(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        chk("div_cycles", n, 32'd10);
        chk("div_lo", LO, 32'hFFFF_FFFD);
        chk("div_hi", HI, 32'hFFFF_FFFF);

        launch(2'b11, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        chk("divu_cycles", n, 32'd10);
        chk("divu_lo", LO, 32'h7FFF_FFFC);
        chk("divu_hi", HI, 32'h0000_0001);

        launch(2'b01, 32'd3, 32'd4);
        write(1'b1, 32'hDEAD_BEEF);
        chk("we_busy_hi_held", HI, 32'h0000_0001);
        wait_done(n);
        chk("we_busy_cycles", n + 1, 32'd5);
        chk("we_busy_hi", HI, 32'h0);
        chk("we_busy_lo", LO, 32'd12);

        launch(2'b11, 32'd100, 32'd7);
        Op = 2'b00; D1 = 32'd5; D2 = 32'd5; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        wait_done(n);
        chk("start_busy_cycles", n + 1, 32'd10);
        chk("start_busy_lo", LO, 32'd14);
        chk("start_busy_hi", HI, 32'd2);
        @(negedge Clk);
        chk("start_busy_idle", {31'b0, Busy}, 32'h0);

        launch(2'b11, 32'd5, 32'd0);
        wait_done(n);
        chk("divz_cycles", n, 32'd10);
        chk("divz_hi", HI, 32'd2);
        chk("divz_lo", LO, 32'd14);

        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        chk("ovf_lo", LO, 32'h8000_0000);
        chk("ovf_hi", HI, 32'h0);

        Op = 2'b01; D1 = 32'd2; D2 = 32'd3; HiLo = 1'b0; We = 1'b1; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0; We = 1'b0;
        chk("startwe_lo_held", LO, 32'h8000_0000);
        wait_done(n);
        chk("startwe_cycles", n, 32'd5);
        chk("startwe_lo", LO, 32'd6);
        chk("startwe_hi", HI, 32'h0);

        launch(2'b11, 32'hFFFF_FFFF, 32'd1);
        repeat (6) @(negedge Clk);
        chk("rst_mid_busy_pre", {31'b0, Busy}, 32'h1);
        Rst = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        chk("rst_mid_busy", {31'b0, Busy}, 32'h0);
        chk("rst_mid_hi", HI, 32'h0);
        chk("rst_mid_lo", LO, 32'h0);
        repeat (10) @(negedge Clk);
        chk("rst_mid_hi_late", HI, 32'h0);
        chk("rst_mid_lo_late", LO, 32'h0);
        chk("rst_mid_busy_late", {31'b0, Busy}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
